// File: rtl/pwm_audio_dac.sv
// Multi-channel PWM / first-order sigma-delta audio DAC with prescaled tick,
// a double-buffered sample shadow register and boundary-aligned duty updates.
module pwm_audio_dac #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        mode,
    input  logic [PRESCALE_WIDTH-1:0]   prescale,
    input  logic [CHANNELS*WIDTH-1:0]   sample_in,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    output logic                        period_start,
    output logic [CHANNELS-1:0]         pwm_out
);

    localparam int unsigned DUTY_BITS = CHANNELS * WIDTH;

    logic [PRESCALE_WIDTH-1:0]      presc_q, presc_d;
    logic [WIDTH-1:0]               cnt_q, cnt_d;
    logic [CHANNELS-1:0][WIDTH:0]   acc_q, acc_d;
    logic [DUTY_BITS-1:0]           duty_q, duty_d;
    logic                           mode_q, mode_d;
    logic [DUTY_BITS-1:0]           shadow_duty_q, shadow_duty_d;
    logic                           shadow_mode_q, shadow_mode_d;
    logic                           shadow_full_q, shadow_full_d;
    logic [CHANNELS-1:0]            pwm_q, pwm_d;
    logic                           period_start_q, period_start_d;

    logic                           tick_c;
    logic                           boundary_c;
    logic                           xfer_c;
    logic                           capture_c;
    logic                           acc_clr_c;
    logic [DUTY_BITS-1:0]           duty_eff_c;
    logic                           mode_eff_c;
    logic [CHANNELS-1:0][WIDTH:0]   sd_sum_c;

    // Tick, period boundary, and the duty/mode that is in force on this tick.
    always_comb begin
        tick_c     = enable && (presc_q == prescale);
        boundary_c = tick_c && (cnt_q == '0);
        xfer_c     = boundary_c && shadow_full_q;
        capture_c  = sample_valid && !shadow_full_q;
        duty_eff_c = xfer_c ? shadow_duty_q : duty_q;
        mode_eff_c = xfer_c ? shadow_mode_q : mode_q;
        acc_clr_c  = xfer_c && (shadow_mode_q != mode_q);
    end

    // Sigma-delta sum per channel; the carry bit is the 1-bit output.
    always_comb begin
        sd_sum_c = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            sd_sum_c[ch] = (acc_clr_c ? {(WIDTH+1){1'b0}} : {1'b0, acc_q[ch][WIDTH-1:0]})
                         + {1'b0, duty_eff_c[ch*WIDTH +: WIDTH]};
        end
    end

    // Next-state logic for the timebase, modulators and shadow handshake.
    always_comb begin
        presc_d        = presc_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        duty_d         = duty_q;
        mode_d         = mode_q;
        shadow_duty_d  = shadow_duty_q;
        shadow_mode_d  = shadow_mode_q;
        shadow_full_d  = shadow_full_q;
        pwm_d          = pwm_q;
        period_start_d = boundary_c;

        if (!enable) begin
            presc_d = '0;
            cnt_d   = '0;
            acc_d   = '0;
            pwm_d   = '0;
        end else if (tick_c) begin
            presc_d = '0;
            cnt_d   = WIDTH'(cnt_q + 1'b1);
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (mode_eff_c) begin
                    acc_d[ch] = sd_sum_c[ch];
                    pwm_d[ch] = sd_sum_c[ch][WIDTH];
                end else begin
                    acc_d[ch] = '0;
                    pwm_d[ch] = (cnt_q < duty_eff_c[ch*WIDTH +: WIDTH]);
                end
            end
        end else begin
            presc_d = PRESCALE_WIDTH'(presc_q + 1'b1);
        end

        // Transfer and capture are mutually exclusive: capture needs an empty shadow.
        if (xfer_c) begin
            duty_d        = shadow_duty_q;
            mode_d        = shadow_mode_q;
            shadow_full_d = 1'b0;
        end else if (capture_c) begin
            shadow_duty_d = sample_in;
            shadow_mode_d = mode;
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            duty_q         <= '0;
            mode_q         <= 1'b0;
            shadow_duty_q  <= '0;
            shadow_mode_q  <= 1'b0;
            shadow_full_q  <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            duty_q         <= duty_d;
            mode_q         <= mode_d;
            shadow_duty_q  <= shadow_duty_d;
            shadow_mode_q  <= shadow_mode_d;
            shadow_full_q  <= shadow_full_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign sample_ready = !shadow_full_q;
    assign period_start = period_start_q;
    assign pwm_out      = pwm_q;

endmodule
